// File: rtl/osc_bank_if.sv
// Handshake and data bundle between a controller and the oscillator bank.
interface osc_bank_if #(
  parameter int W   = 32,
  parameter int NCH = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           Enable;
  logic           Busy;
  logic           Ld_valid;
  logic           Ld_ready;
  logic           Ld_clr;
  logic [CHW-1:0] Ld_ch;
  logic [W-1:0]   Ld_init1;
  logic [W-1:0]   Ld_init2;
  logic           Out_valid;
  logic [CHW-1:0] Out_ch;
  logic [W-1:0]   Out1;
  logic [W-1:0]   Out2;
  logic [NCH-1:0] Sat;

  modport master (
    output Enable, Ld_valid, Ld_clr, Ld_ch, Ld_init1, Ld_init2,
    input  Busy, Ld_ready, Out_valid, Out_ch, Out1, Out2, Sat
  );

  modport slave (
    input  Enable, Ld_valid, Ld_clr, Ld_ch, Ld_init1, Ld_init2,
    output Busy, Ld_ready, Out_valid, Out_ch, Out1, Out2, Sat
  );
endinterface

// File: rtl/osc_bank.sv
// Time-multiplexed bank of recursive sine oscillators: y[n] = a*y[n-1] - y[n-2].
// One shared multiplier walks all channels once per Enable.
//
// state | meaning
// IDLE  | waiting; loads accepted, Enable starts a sweep
// SWEEP | one channel per cycle, channels 0..NCH-1 in order
module osc_bank #(
  parameter int W    = 32,
  parameter int FRAC = 29,
  parameter int NCH  = 4
) (
  input logic       Fg_CLK,
  input logic       RESET,
  osc_bank_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
  localparam logic [CHW:0]   NCH_W   = (CHW + 1)'(NCH);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;

  logic signed [W-1:0] y1_q [NCH];
  logic signed [W-1:0] y2_q [NCH];
  logic signed [W-1:0] a_q  [NCH];
  logic [NCH-1:0]      act_q;
  logic [NCH-1:0]      sat_q;

  logic           out_valid_q;
  logic [CHW-1:0] out_ch_q;
  logic [W-1:0]   out1_q;
  logic [W-1:0]   out2_q;

  logic ld_ready, ld_fire, ld_ch_ok, upd;

  logic signed [W-1:0]   a_cur, y1_cur, y2_cur, y_new;
  logic signed [2*W-1:0] prod, prod_sh;
  logic signed [2*W:0]   diff;
  logic                  ovf;

  assign ld_ready = (state_q == IDLE) && !RESET;
  assign ld_fire  = bus.Ld_valid && ld_ready;
  // Channel numbers beyond the bank are accepted on the handshake but dropped.
  assign ld_ch_ok = ({1'b0, bus.Ld_ch} < NCH_W);
  assign upd      = (state_q == SWEEP) && act_q[ch_q];

  assign a_cur  = a_q[ch_q];
  assign y1_cur = y1_q[ch_q];
  assign y2_cur = y2_q[ch_q];

  // Shared multiply, floor shift, subtract and clamp for the channel in its slot.
  always_comb begin
    prod    = (2*W)'(a_cur) * (2*W)'(y1_cur);
    prod_sh = prod >>> FRAC;
    diff    = (2*W+1)'(prod_sh) - (2*W+1)'(y2_cur);
    // In range only if every bit above the result sign matches it.
    ovf     = (diff[2*W:W-1] != {(W+2){diff[2*W]}});
    if (!ovf) begin
      y_new = diff[W-1:0];
    end else if (diff[2*W]) begin
      y_new = {1'b1, {(W-1){1'b0}}};
    end else begin
      y_new = {1'b0, {(W-1){1'b1}}};
    end
  end

  // Next-state: a load in the same cycle swallows Enable; sweep ends on the last channel.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        ch_d = '0;
        if (bus.Enable && !ld_fire) begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        ch_d = ch_q + 1'b1;
        if (ch_q == LAST_CH) begin
          state_d = IDLE;
          ch_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = '0;
      end
    endcase
  end

  // State and sweep-slot registers.
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Per-channel oscillator state: loads in IDLE, recursion updates in SWEEP.
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        y1_q[i] <= '0;
        y2_q[i] <= '0;
        a_q[i]  <= '0;
      end
      act_q <= '0;
      sat_q <= '0;
    end else if (ld_fire && ld_ch_ok) begin
      if (bus.Ld_clr) begin
        act_q[bus.Ld_ch] <= 1'b0;
      end else begin
        y1_q[bus.Ld_ch]  <= bus.Ld_init1;
        y2_q[bus.Ld_ch]  <= '0;
        a_q[bus.Ld_ch]   <= bus.Ld_init2;
        act_q[bus.Ld_ch] <= 1'b1;
        sat_q[bus.Ld_ch] <= 1'b0;
      end
    end else if (upd) begin
      y2_q[ch_q] <= y1_cur;
      y1_q[ch_q] <= y_new;
      if (ovf) begin
        sat_q[ch_q] <= 1'b1;
      end
    end
  end

  // Output register: strobe for one cycle per updated channel, hold data otherwise.
  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (upd) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= ch_q;
        out1_q      <= y_new;
        out2_q      <= y1_cur;
      end
    end
  end

  assign bus.Busy      = (state_q == SWEEP);
  assign bus.Ld_ready  = ld_ready;
  assign bus.Out_valid = out_valid_q;
  assign bus.Out_ch    = out_ch_q;
  assign bus.Out1      = out1_q;
  assign bus.Out2      = out2_q;
  assign bus.Sat       = sat_q;
endmodule

// File: tb/tb_osc_bank.sv
module tb_osc_bank;
  localparam int W    = 32;
  localparam int FRAC = 29;
  localparam int NCH  = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osc_bank_if #(.W(W), .NCH(NCH)) bif();

  osc_bank #(.W(W), .FRAC(FRAC), .NCH(NCH)) dut (
    .Fg_CLK (clk),
    .RESET  (rst),
    .bus    (bif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: per-channel integer state, plus a count of sweep slots left.
  int          m_y1 [NCH];
  int          m_y2 [NCH];
  int          m_a  [NCH];
  bit          m_act[NCH];
  logic [3:0]  m_sat;
  int          m_left = 0;
  int          mch;
  logic        e_valid;
  int          e_ch, e_o1, e_o2;
  longint      p, q, d;
  int          cyc = 0;
  bit          chk_on = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_y1[i] = 0; m_y2[i] = 0; m_a[i] = 0; m_act[i] = 0;
      end
      m_sat = '0; m_left = 0;
      e_valid = 0; e_ch = 0; e_o1 = 0; e_o2 = 0;
    end else if (m_left > 0) begin
      e_valid = 0;
      mch = NCH - m_left;
      if (m_act[mch]) begin
        p = longint'(m_a[mch]) * longint'(m_y1[mch]);
        q = p >>> FRAC;
        d = q - longint'(m_y2[mch]);
        if (d > MAXV) begin d = MAXV; m_sat[mch] = 1'b1; end
        else if (d < MINV) begin d = MINV; m_sat[mch] = 1'b1; end
        m_y2[mch] = m_y1[mch];
        m_y1[mch] = int'(d);
        e_valid = 1; e_ch = mch; e_o1 = m_y1[mch]; e_o2 = m_y2[mch];
      end
      m_left--;
    end else begin
      e_valid = 0;
      if (bif.Ld_valid) begin
        if (int'(bif.Ld_ch) < NCH) begin
          if (bif.Ld_clr) m_act[bif.Ld_ch] = 0;
          else begin
            m_y1[bif.Ld_ch] = int'(bif.Ld_init1);
            m_y2[bif.Ld_ch] = 0;
            m_a[bif.Ld_ch]  = int'(bif.Ld_init2);
            m_act[bif.Ld_ch] = 1;
            m_sat[bif.Ld_ch] = 1'b0;
          end
        end
      end else if (bif.Enable) begin
        m_left = NCH;
      end
    end
    chk_on = 1;
  end

  logic [31:0] log_ch[$], log_o1[$], log_o2[$];
  int          log_cyc[$];
  int          hs_cyc[$];

  // Compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy",      bif.Busy,      m_left > 0);
      check("ld_ready",  bif.Ld_ready,  (m_left == 0) && !rst);
      check("out_valid", bif.Out_valid, e_valid);
      check("out_ch",    bif.Out_ch,    e_ch);
      check("out1",      bif.Out1,      e_o1);
      check("out2",      bif.Out2,      e_o2);
      check("sat",       bif.Sat,       m_sat);
      if (bif.Out_valid === 1'b1) begin
        log_ch.push_back(bif.Out_ch);
        log_o1.push_back(bif.Out1);
        log_o2.push_back(bif.Out2);
        log_cyc.push_back(cyc);
      end
      if (bif.Ld_valid && bif.Ld_ready) hs_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    log_ch.delete(); log_o1.delete(); log_o2.delete(); log_cyc.delete(); hs_cyc.delete();
  endtask

  task automatic load(input int ch, input bit clr, input logic [31:0] i1, input logic [31:0] i2);
    bif.Ld_ch = 2'(ch); bif.Ld_clr = clr; bif.Ld_init1 = i1; bif.Ld_init2 = i2;
    bif.Ld_valid = 1'b1;
    tick(1);
    bif.Ld_valid = 1'b0;
  endtask

  task automatic sweep();
    bif.Enable = 1'b1;
    tick(1);
    bif.Enable = 1'b0;
    tick(NCH + 1);
  endtask

  int t;
  int idx;
  int exp39 [8] = '{0, -1000, 0, 1000, 0, -1000, 0, 1000};
  int exp40a[3] = '{200, 300, 400};
  int exp40b[3] = '{100, 200, 300};

  initial begin
    bif.Enable = 0; bif.Ld_valid = 0; bif.Ld_clr = 0; bif.Ld_ch = '0;
    bif.Ld_init1 = '0; bif.Ld_init2 = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_sat",  bif.Sat,  4'b0000);
    check("rst_out1", bif.Out1, 32'd0);
    check("rst_busy", bif.Busy, 1'b0);
    tick(1);

    // ch0: a = 0 gives a period-4 sequence
    load(0, 0, 32'd1000, 32'd0);
    clear_logs();
    repeat (8) sweep();
    idx = 0;
    foreach (log_ch[i]) begin
      if (log_ch[i] == 0) begin
        if (idx < 8) check($sformatf("req39_out1[%0d]", idx), log_o1[i], exp39[idx]);
        idx++;
      end
    end
    check("req39_count", idx, 8);

    // ch1: a = 2.0 gives linear growth
    clear_logs();
    load(1, 0, 32'd100, 32'h4000_0000);
    repeat (3) sweep();
    idx = 0;
    foreach (log_ch[i]) begin
      if (log_ch[i] == 1) begin
        if (idx < 3) begin
          check($sformatf("req40_out1[%0d]", idx), log_o1[i], exp40a[idx]);
          check($sformatf("req40_out2[%0d]", idx), log_o2[i], exp40b[idx]);
        end
        idx++;
      end
    end
    check("req40_count", idx, 3);

    // ch2: positive overflow clamps and sets the sticky flag; reload clears it
    load(2, 0, 32'h4000_0000, 32'h4000_0000);
    clear_logs();
    sweep();
    idx = 0;
    foreach (log_ch[i]) begin
      if (log_ch[i] == 2) begin
        check("req41_clamp", log_o1[i], 32'h7FFF_FFFF);
        idx++;
      end
    end
    check("req41_count", idx, 1);
    check("req41_sat", bif.Sat, 4'b0100);
    load(2, 0, 32'd1, 32'd0);
    check("req41_sat_clr", bif.Sat, 4'b0000);

    // ch0 and ch3 active only; Enable pulses during the sweep are ignored
    load(1, 1, 32'd0, 32'd0);
    load(2, 1, 32'd0, 32'd0);
    load(3, 0, 32'd5, 32'd0);
    clear_logs();
    t = cyc;
    bif.Enable = 1'b1; tick(1);
    bif.Enable = 1'b1; tick(1);
    bif.Enable = 1'b0; tick(1);
    bif.Enable = 1'b1; tick(1);
    bif.Enable = 1'b0; tick(4);
    check("req42_count", log_cyc.size(), 2);
    if (log_cyc.size() == 2) begin
      check("req42_cyc0", log_cyc[0], t + 2);
      check("req42_ch0",  log_ch[0],  0);
      check("req42_cyc1", log_cyc[1], t + 5);
      check("req42_ch1",  log_ch[1],  3);
    end

    // load and Enable together: load wins, no sweep
    clear_logs();
    bif.Ld_ch = 2'd1; bif.Ld_clr = 0; bif.Ld_init1 = 32'd7; bif.Ld_init2 = 32'd0;
    bif.Ld_valid = 1'b1; bif.Enable = 1'b1;
    tick(1);
    bif.Ld_valid = 1'b0; bif.Enable = 1'b0;
    check("req43_busy0", bif.Busy, 1'b0);
    tick(1);
    check("req43_busy1", bif.Busy, 1'b0);
    check("req43_hs", hs_cyc.size(), 1);

    // Ld_valid held through a sweep is taken only back in IDLE
    clear_logs();
    t = cyc;
    bif.Enable = 1'b1; tick(1);
    bif.Enable = 1'b0;
    bif.Ld_ch = 2'd3; bif.Ld_clr = 1'b1; bif.Ld_valid = 1'b1;
    tick(5);
    bif.Ld_valid = 1'b0;
    tick(2);
    check("req43_hold_count", hs_cyc.size(), 1);
    if (hs_cyc.size() == 1) check("req43_hold_cyc", hs_cyc[0], t + 5);

    // reset in the second cycle of a sweep
    t = cyc;
    bif.Enable = 1'b1; tick(1);
    bif.Enable = 1'b0; tick(1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    check("req44_busy",  bif.Busy,      1'b0);
    check("req44_valid", bif.Out_valid, 1'b0);
    clear_logs();
    sweep();
    sweep();
    check("req44_no_out", log_cyc.size(), 0);
    check("req44_sat", bif.Sat, 4'b0000);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/osc_bank.md
OSC_BANK -- requirements
Module: osc_bank

Interface
REQ-001 Parameter W, default 32: signed sample and coefficient width.
REQ-002 Parameter FRAC, default 29: coefficient fractional bits; the product is shifted right by FRAC.
REQ-003 Parameter NCH, default 4, range 1..16: number of time-multiplexed oscillator channels; CHW = max(1, clog2(NCH)).
REQ-004 Fg_CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RESET  in  1  reset, synchronous and active-high.
REQ-006 Enable  in  1  single-cycle request to advance every active channel by one sample.
REQ-007 Busy  out  1  high while a sweep is in progress.
REQ-008 Ld_valid  in  1  channel load/clear request.
REQ-009 Ld_ready  out  1  load accepted when Ld_valid and Ld_ready are both high.
REQ-010 Ld_clr  in  1  qualifies a load: 1 = deactivate the channel; 0 = initialise and activate it.
REQ-011 Ld_ch  in  CHW  target channel; values >= NCH are accepted and discarded.
REQ-012 Ld_init1  in  W  initial y[n-1] (sin B).
REQ-013 Ld_init2  in  W  coefficient a = 2cos(w), signed, FRAC fractional bits.
REQ-014 Out_valid  out  1  one-cycle strobe for a new sample.
REQ-015 Out_ch  out  CHW  channel of the sample.
REQ-016 Out1  out  W  new sample y[n].
REQ-017 Out2  out  W  previous sample y[n-1].
REQ-018 Sat  out  NCH  sticky per-channel saturation flags.

Function
REQ-019 Per-channel state: y1, y2 and a, each W bits, plus an Active bit; all are held in register arrays.
REQ-020 FSM states: IDLE and SWEEP. The block leaves IDLE for SWEEP only when Enable=1 is sampled and no load is accepted in that cycle.
REQ-021 SWEEP lasts exactly NCH cycles and visits channels 0..NCH-1 in order, one channel per cycle; the block then returns to IDLE.
REQ-022 Busy = (state == SWEEP); Ld_ready = (state == IDLE) and not RESET.
REQ-023 Enable is ignored while in SWEEP; it is not queued.
REQ-024 If a load is accepted in the same cycle as Enable, the load takes priority and that Enable is dropped.
REQ-025 Accepted load with Ld_clr=0 performs, in one cycle: y1 = Ld_init1, y2 = 0, a = Ld_init2, Active = 1, Sat[ch] = 0.
REQ-026 Accepted load with Ld_clr=1 sets Active = 0 and leaves y1, y2, a and Sat unchanged.
REQ-027 Per active channel, the update computes p = a*y1 as a signed 2W-bit product, q = p >>> FRAC (arithmetic shift, floor), and d = q - y2 at 2W+1 bits.
REQ-028 If d is outside [-2^(W-1), 2^(W-1)-1], d is clamped to the nearest bound and Sat[ch] is set; Sat[ch] stays set until reset or a Ld_clr=0 load of that channel.
REQ-029 The update writes y2 = y1 and y1 = clamped d.
REQ-030 The datapath has one shared multiplier, time-multiplexed across channels.
REQ-031 Inactive channels still consume their SWEEP slot, keep their state unchanged, and produce no Out_valid.
REQ-032 Output latency is 1 cycle. For a channel processed in cycle t, Out_valid=1 in cycle t+1, with Out_ch = ch, Out1 = new y1 and Out2 = new y2.
REQ-033 Out_valid is low in all other cycles. Out_ch, Out1 and Out2 hold their last values when Out_valid is low.
REQ-034 Timing of a sweep: Enable sampled in cycle t; Busy is high for cycles t+1..t+NCH; the last output appears in cycle t+NCH+1; Enable is accepted again from cycle t+NCH+1.
REQ-035 With NCH=1, SWEEP lasts 1 cycle and all rules above still apply.

Reset
REQ-036 When RESET=1 at a clock edge: state = IDLE; all y1, y2 and a = 0; all Active = 0; Sat = 0; Out_valid = 0; Out_ch = 0; Out1 = 0; Out2 = 0.
REQ-037 RESET during SWEEP aborts the sweep. No Out_valid is produced in the following cycle, and no channel state survives.
REQ-038 RESET has priority over Enable and over loads.

Verification (W=32, FRAC=29, NCH=4)
REQ-039 Load ch0 with init1=1000, a=0, then 8 Enables -> ch0 Out1 sequence 0, -1000, 0, 1000, 0, -1000, 0, 1000.
REQ-040 Load ch1 with init1=100, a=0x4000_0000 (2.0), then 3 Enables -> Out1 = 200, 300, 400; Out2 = 100, 200, 300.
REQ-041 Load ch2 with init1=0x4000_0000, a=0x4000_0000, then 1 Enable -> Out1 = 0x7FFF_FFFF and Sat = 4'b0100. Reload ch2 -> Sat = 4'b0000.
REQ-042 Channels 0 and 3 active, 1 and 2 inactive, Enable in cycle t -> Busy high for t+1..t+4; Out_valid in cycles t+2 (ch0) and t+5 (ch3) only; Enable pulses during t+1..t+4 are ignored.
REQ-043 Ld_valid and Enable asserted in the same IDLE cycle -> load applied, no sweep starts, Busy stays 0; a Ld_valid held high during SWEEP is accepted only once the block is back in IDLE.
REQ-044 RESET asserted at the second cycle of a sweep -> Busy = 0 and Out_valid = 0 in the next cycle; all channels inactive, and a following Enable produces no Out_valid.
